// File: rtl/clz_sequencer.sv
// -----------------------------------------------------------------------------
// clz_sequencer
//
// Multi-cycle count-leading-zeros / count-leading-ones unit for the EX stage.
// The operand is loaded into a shift register and scanned MSB-first, STEP bits
// per cycle. The scan stops at the first window that holds the terminating
// bit. A stall is requested from the accept cycle until the count is ready.
//
// Configuration macro: CLZ_CLO_EN
//   defined   - op = 1 selects CLO (the operand is inverted on load)
//   undefined - op is ignored and every request is a CLZ
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   count request, accepted in IDLE or DONE only
//   op       in   0 = CLZ, 1 = CLO
//   operand  in   DATA_W-bit source value, sampled on the accept cycle
//   flush    in   abort any operation, return to IDLE
//   busy     out  high in every SCAN cycle
//   stall    out  pipeline hold: accept this cycle or SCAN
//   done     out  one-cycle pulse, result valid
//   result   out  count 0..DATA_W, held until the next done
// -----------------------------------------------------------------------------
module clz_sequencer #(
    parameter int DATA_W = 32,
    parameter int STEP   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              op,
    input  logic [DATA_W-1:0] operand,
    input  logic              flush,
    output logic              busy,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] result
);
    // Wide enough to hold DATA_W itself (all-zero operand).
    localparam int CW = $clog2(DATA_W) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] STEP_C = CW'(STEP);
    localparam logic [CW-1:0] FULL_C = CW'(DATA_W);

    generate
        if ((DATA_W % STEP) != 0) begin : g_bad_step
            $error("DATA_W must be a multiple of STEP");
        end
    endgenerate

    logic [1:0]        state_reg;
    logic [DATA_W-1:0] shreg_reg;
    logic [CW-1:0]     cnt_reg;
    logic [DATA_W-1:0] result_reg;

    logic              accept;
    logic [DATA_W-1:0] load_value;
    logic [STEP-1:0]   window;
    logic [CW-1:0]     win_lz;
    logic [CW-1:0]     cnt_step;

    assign accept = start && !flush && ((state_reg == S_IDLE) || (state_reg == S_DONE));

`ifdef CLZ_CLO_EN
    // CLO is CLZ of the inverted operand.
    assign load_value = op ? ~operand : operand;
`else
    logic unused_op;
    assign unused_op  = op;
    assign load_value = operand;
`endif

    assign window   = shreg_reg[DATA_W-1 -: STEP];
    assign cnt_step = cnt_reg + STEP_C;

    // Leading zeros inside the window: higher set bits overwrite lower ones,
    // so the most significant 1 decides. Only used when the window is nonzero.
    always_comb begin
        win_lz = '0;
        for (int i = 0; i < STEP; i++) begin
            if (window[i]) begin
                win_lz = CW'(STEP - 1 - i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            shreg_reg  <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
        end else if (flush) begin
            // Abort: no done, result untouched.
            state_reg <= S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        shreg_reg <= load_value;
                        cnt_reg   <= '0;
                        state_reg <= S_SCAN;
                    end else begin
                        state_reg <= S_IDLE;
                    end
                end
                S_SCAN: begin
                    if (window != '0) begin
                        cnt_reg    <= cnt_reg + win_lz;
                        result_reg <= DATA_W'(cnt_reg + win_lz);
                        state_reg  <= S_DONE;
                    end else if (cnt_step == FULL_C) begin
                        cnt_reg    <= FULL_C;
                        result_reg <= DATA_W'(FULL_C);
                        state_reg  <= S_DONE;
                    end else begin
                        cnt_reg   <= cnt_step;
                        shreg_reg <= shreg_reg << STEP;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign busy   = (state_reg == S_SCAN);
    assign stall  = accept || (state_reg == S_SCAN);
    assign done   = (state_reg == S_DONE);
    assign result = result_reg;

endmodule

// File: doc/clz_sequencer.md
# clz_sequencer

Multi-cycle sequencer for the MIPS32 CLZ/CLO instructions in the EX stage. It loads a 32-bit operand and scans it MSB-first, STEP bits per cycle, stopping at the first window that holds the terminating bit. It exits early and drives a stall to the pipeline control until the count is ready. It also returns to idle cleanly on an exception flush.

## Interface
- DATA_W, 32, operand width; must be a multiple of STEP.
- STEP, 4, bits examined per SCAN cycle; allowed values 1, 2, 4, 8.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a count; accepted only in IDLE or DONE.
- op  in  1  0 = CLZ (count leading zeros), 1 = CLO (count leading ones).
- operand  in  DATA_W  source register value; sampled only on the accept cycle.
- flush  in  1  exception/flush; aborts any operation.
- busy  out  1  high while in SCAN.
- stall  out  1  pipeline hold request: (start accepted this cycle) OR (state == SCAN).
- done  out  1  one-cycle pulse; result valid.
- result  out  DATA_W  count, 0..DATA_W; holds its value until the next done.

## Operation
- States:
  - IDLE:
    - start & !flush: load the shift register with operand (bitwise inverted when op = 1), set cnt = 0, go to SCAN.
  - SCAN: inspect the top STEP bits of the shift register.
    - Window contains a 1: cnt += (leading zeros inside window); go to DONE.
    - Window all zeros and cnt + STEP == DATA_W: cnt = DATA_W; go to DONE.
    - Otherwise: cnt += STEP; shift left by STEP; stay in SCAN.
  - DONE: result <= cnt; done = 1.
    - start & !flush: accepted exactly as in IDLE (back-to-back), go to SCAN.
    - Otherwise go to IDLE.
- start in SCAN is ignored; the requester must hold the instruction, which is guaranteed because stall is high.
- flush has priority over everything:
  - From any state it forces IDLE at the next edge.
  - No done is produced; result is unchanged.
  - A start in the same cycle as flush is dropped.
- Counter width is $clog2(DATA_W)+1 so that DATA_W itself is representable; result is zero-extended.
- Async reset (rst_n = 0), including mid-SCAN: state = IDLE, busy = 0, stall = 0, done = 0, result = 0, internal count and shift register = 0.

## Timing
- Accept cycle t (start high in IDLE/DONE): stall = 1 combinationally in cycle t.
- Scan cycles are t+1 .. t+k, where k = 1-based index of the window containing the terminating bit (window 1 = bits DATA_W-1 .. DATA_W-STEP).
- An all-zero window sequence gives k = DATA_W/STEP.
- DONE is in cycle t+k+1, with done = 1 and result valid. Latency = k+1 cycles: minimum 2, maximum DATA_W/STEP + 1 (9 at defaults).
- stall is 0 in the DONE cycle, so the EX instruction advances and captures result that cycle.
- busy = 1 in exactly the k scan cycles.

## Configuration
- CLZ_CLO_EN:
  - Defined: op selects CLZ or CLO as described.
  - Undefined: op is ignored, the inversion logic is removed, and every request is CLZ.

## Test plan
- CLZ 0x8000_0000 accepted at t -> one SCAN cycle, done at t+2, result = 0.
- CLZ 0x0001_0000 -> busy for 4 cycles, done at t+5, result = 15.
- CLZ 0x0000_0000 -> busy for 8 cycles, done at t+9, result = 32; with CLZ_CLO_EN undefined and op = 1 the response is identical.
- CLO 0xFFFF_FFF0 (CLZ_CLO_EN defined) -> done at t+9, result = 28; CLO 0x7FFF_FFFF -> done at t+2, result = 0.
- CLZ 0 with flush at t+3 -> IDLE at t+4, no done, result keeps its previous value (15); start at t+5 with 0x8000_0000 -> done at t+7, result = 0.
- start re-asserted during SCAN -> ignored, no second done.
- Back-to-back start in the DONE cycle -> new op runs, done k+1 cycles later.
- rst_n low mid-SCAN -> all outputs 0 immediately and state IDLE.
